// File: rtl/regfile_sync.sv
//------------------------------------------------------------------------------
// Module      : regfile_sync
// Description : 2**DEPTH x WIDTH register file, one write port, two registered
//               read ports, hardware clear sweep to INIT_VAL after reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sync #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_ni,
    input  logic             we_i,
    input  logic [DEPTH-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_a_i,
    input  logic [DEPTH-1:0] raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic             valid_a_o,
    input  logic             re_b_i,
    input  logic [DEPTH-1:0] raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    output logic             valid_b_o,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned      c_WORDS     = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] c_LAST_ADDR = {DEPTH{1'b1}};
    localparam logic [0:0]       c_ST_CLEAR  = 1'b0;
    localparam logic [0:0]       c_ST_IDLE   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DEPTH-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;

    logic [WIDTH-1:0] mem [0:c_WORDS-1];

    logic w_accept;
    logic w_wr_en;
    logic w_attempt;

    assign w_accept  = !cs_ni && (state_q == c_ST_IDLE);
    assign w_wr_en   = w_accept && we_i;
    assign w_attempt = !cs_ni && (we_i || re_a_i || re_b_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= c_ST_CLEAR;
            ptr_q     <= '0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    // Storage carries no reset; the sweep that follows reset initialises it.
    always_ff @(posedge clk_i) begin
        if (state_q == c_ST_CLEAR) begin
            mem[ptr_q] <= INIT_VAL;
        end else if (w_wr_en) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            c_ST_CLEAR: begin
                if (ptr_q == c_LAST_ADDR) begin
                    state_d = c_ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                if (clear_i) begin
                    state_d = c_ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Reads see the same-cycle write data on an address match (write-first).
    always_comb begin
        busy_d    = (state_d == c_ST_CLEAR);
        err_d     = (state_q == c_ST_CLEAR) && w_attempt;
        valid_a_d = w_accept && re_a_i;
        valid_b_d = w_accept && re_b_i;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (valid_a_d) begin
            rdata_a_d = (w_wr_en && (waddr_i == raddr_a_i)) ? wdata_i : mem[raddr_a_i];
        end
        if (valid_b_d) begin
            rdata_b_d = (w_wr_en && (waddr_i == raddr_b_i)) ? wdata_i : mem[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
    assign valid_a_o = valid_a_q;
    assign valid_b_o = valid_b_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sync.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_sync
// Description : Self-checking bench for regfile_sync with a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sync;

    localparam int unsigned c_W     = 8;
    localparam int unsigned c_D     = 4;
    localparam int          c_N     = 16;
    localparam logic [7:0]  c_INIT  = 8'hA5;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [3:0] raddr_a;
    logic [7:0] rdata_a;
    logic       valid_a;
    logic       re_b;
    logic [3:0] raddr_b;
    logic [7:0] rdata_b;
    logic       valid_b;
    logic       clear;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sync #(
        .WIDTH   (c_W),
        .DEPTH   (c_D),
        .INIT_VAL(c_INIT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cs_ni    (cs_n),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .re_a_i   (re_a),
        .raddr_a_i(raddr_a),
        .rdata_a_o(rdata_a),
        .valid_a_o(valid_a),
        .re_b_i   (re_b),
        .raddr_b_i(raddr_b),
        .rdata_b_o(rdata_b),
        .valid_b_o(valid_b),
        .clear_i  (clear),
        .busy_o   (busy),
        .err_o    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep_pos is the next address the clear sweep will
    // write, or -1 when the array is available for accesses.
    logic [7:0] m_mem [c_N];
    int         sweep_pos;
    logic [7:0] e_rdata_a, e_rdata_b;
    logic       e_valid_a, e_valid_b, e_busy, e_err;
    bit         model_live = 1'b0;

    initial begin
        sweep_pos = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_live = 1'b1;
                sweep_pos  = 0;
                e_rdata_a  = 8'h00;
                e_rdata_b  = 8'h00;
                e_valid_a  = 1'b0;
                e_valid_b  = 1'b0;
                e_err      = 1'b0;
                e_busy     = 1'b1;
            end else if (model_live) begin
                if (sweep_pos >= 0) begin
                    m_mem[sweep_pos] = c_INIT;
                    e_err     = !cs_n && (we || re_a || re_b);
                    e_valid_a = 1'b0;
                    e_valid_b = 1'b0;
                    sweep_pos = (sweep_pos == c_N - 1) ? -1 : sweep_pos + 1;
                end else begin
                    e_err = 1'b0;
                    if (!cs_n && we) m_mem[waddr] = wdata;
                    e_valid_a = !cs_n && re_a;
                    e_valid_b = !cs_n && re_b;
                    if (e_valid_a) e_rdata_a = m_mem[raddr_a];
                    if (e_valid_b) e_rdata_b = m_mem[raddr_b];
                    if (clear) sweep_pos = 0;
                end
                e_busy = (sweep_pos >= 0);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model rdata_a", rdata_a, e_rdata_a);
            check("model rdata_b", rdata_b, e_rdata_b);
            check("model valid_a", valid_a, e_valid_a);
            check("model valid_b", valid_b, e_valid_b);
            check("model busy",    busy,    e_busy);
            check("model err",     err,     e_err);
        end
    end

    task automatic drive(input logic c, input logic w, input logic [3:0] wa, input logic [7:0] wd,
                         input logic ra_en, input logic [3:0] ra, input logic rb_en,
                         input logic [3:0] rb, input logic clr);
        cs_n = c; we = w; waddr = wa; wdata = wd;
        re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb; clear = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            idle();
            k++;
        end
        if (busy) check("wait_idle timeout", 1, 0);
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (busy && n < 40);
        check(name, n, c_N);
    endtask

    initial begin
        rst = 1'b0; cs_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clear = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy",    busy,    1);
        check("reset valid_a", valid_a, 0);
        check("reset rdata_a", rdata_a, 0);
        check("reset err",     err,     0);
        rst = 1'b0;
        count_sweep("initial sweep length");

        for (int i = 0; i < c_N; i++) begin
            drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0, 4'd0, 1'b0);
            check("init read value", rdata_a, 8'hA5);
            check("init read valid", valid_a, 1);
        end

        drive(1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 1'b1, 4'd6, 1'b0);
        check("wr/rd a data", rdata_a, 8'h3C);
        check("wr/rd b data", rdata_b, 8'hA5);
        check("wr/rd valids", {valid_a, valid_b}, 2'b11);
        idle();
        check("valid pulse", {valid_a, valid_b}, 2'b00);

        drive(1'b0, 1'b1, 4'd9, 8'h77, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0);
        check("bypass a", rdata_a, 8'h77);
        check("bypass b", rdata_b, 8'h77);

        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        check("clear busy", busy, 1);
        idle();
        drive(1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("sweep err pulse", err, 1);
        idle();
        check("sweep err drop", err, 0);
        wait_idle();
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        check("dropped write", rdata_a, 8'hA5);

        drive(1'b0, 1'b1, 4'd3, 8'h11, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        check("cs setup", rdata_a, 8'h11);
        drive(1'b1, 1'b1, 4'd3, 8'hEE, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        check("cs off valid", valid_a, 0);
        check("cs off err",   err,     0);
        check("cs off hold",  rdata_a, 8'h11);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        check("cs off no write", rdata_a, 8'h11);

        for (int i = 0; i < 600; i++) begin
            drive(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom),
                  logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  logic'($urandom_range(0, 29) == 0));
        end
        wait_idle();

        drive(1'b0, 1'b1, 4'd0, 8'h5A, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1);
        check("pre-reset rdata", rdata_a, 8'h5A);
        repeat (6) idle();
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
        check("pre-reset err", err, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy",    busy,    1);
        check("async rst err",     err,     0);
        check("async rst rdata_a", rdata_a, 0);
        check("async rst rdata_b", rdata_b, 0);
        check("async rst valid",   {valid_a, valid_b}, 2'b00);
        idle();
        idle();
        rst = 1'b0;
        count_sweep("restart sweep length");
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 1'b1, 4'd15, 1'b0);
        check("restart addr0",  rdata_a, 8'hA5);
        check("restart addr15", rdata_b, 8'hA5);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
